// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, issues word reads to a
//                1-cycle-latency instruction memory, buffers responses in a
//                prefetch FIFO and hands them to decode over valid/ready.
//                Redirects flush buffered and in-flight fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                XLEN              = 32,
    parameter int                INSTRUCTION_WIDTH = 32,
    parameter int                IM_MEM_DEPTH      = 256,
    parameter int                FIFO_DEPTH        = 4,
    parameter logic [XLEN-1:0]   RESET_PC          = '0
) (
    input  logic                               clk,
    input  logic                               rstN,
    input  logic                               redirectValid,
    input  logic [XLEN-1:0]                    redirectPc,
    output logic                               imemReq,
    output logic [$clog2(IM_MEM_DEPTH)-1:0]    imemAddr,
    input  logic [INSTRUCTION_WIDTH-1:0]       imemData,
    output logic                               idValid,
    input  logic                               idReady,
    output logic [XLEN-1:0]                    idPc,
    output logic [INSTRUCTION_WIDTH-1:0]       idInstr,
    output logic [$clog2(FIFO_DEPTH):0]        fifoCount
);

    localparam int              c_ADDR_WIDTH = $clog2(IM_MEM_DEPTH);
    localparam int              c_PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int              c_CNT_WIDTH  = c_PTR_WIDTH + 1;
    localparam int              c_OCC_WIDTH  = c_CNT_WIDTH + 1;
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0]              r_fetchPc;
    logic                         r_inflightValid;
    logic [XLEN-1:0]              r_inflightPc;
    logic [c_PTR_WIDTH-1:0]       r_rdPtr;
    logic [c_PTR_WIDTH-1:0]       r_wrPtr;
    logic [c_CNT_WIDTH-1:0]       r_count;
    logic [XLEN-1:0]              r_pcMem    [FIFO_DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] r_instrMem [FIFO_DEPTH];

    logic                         w_pop;
    logic                         w_push;
    logic [c_OCC_WIDTH-1:0]       w_occupancy;
    logic [XLEN-1:0]              w_redirectTarget;

    // Handshake, issue decision and head-of-FIFO presentation
    always_comb begin
        w_redirectTarget = redirectPc & c_ALIGN_MASK;
        idValid          = (r_count != '0) && !redirectValid;
        w_pop            = idValid && idReady;
        w_push           = r_inflightValid && !redirectValid;
        // Slots that will be taken once the outstanding read lands, net of
        // the entry decode removes this cycle; a new read may only issue if
        // its response is guaranteed a slot.
        w_occupancy      = {1'b0, r_count} + c_OCC_WIDTH'(r_inflightValid)
                         - c_OCC_WIDTH'(w_pop);
        imemReq          = rstN && !redirectValid
                         && (w_occupancy < c_OCC_WIDTH'(FIFO_DEPTH));
        imemAddr         = r_fetchPc[c_ADDR_WIDTH+1:2];
        idPc             = r_pcMem[r_rdPtr];
        idInstr          = r_instrMem[r_rdPtr];
        fifoCount        = r_count;
    end

    // PC, outstanding-read tracking and FIFO bookkeeping; redirect wins over
    // push, pop and issue
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_fetchPc       <= RESET_PC;
            r_inflightValid <= 1'b0;
            r_inflightPc    <= '0;
            r_rdPtr         <= '0;
            r_wrPtr         <= '0;
            r_count         <= '0;
        end else if (redirectValid) begin
            r_fetchPc       <= w_redirectTarget;
            r_inflightValid <= 1'b0;
            r_rdPtr         <= '0;
            r_wrPtr         <= '0;
            r_count         <= '0;
        end else begin
            if (imemReq) begin
                r_inflightValid <= 1'b1;
                r_inflightPc    <= r_fetchPc;
                r_fetchPc       <= r_fetchPc + XLEN'(4);
            end else begin
                r_inflightValid <= 1'b0;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_WIDTH'(1);
            end
            r_count <= r_count + c_CNT_WIDTH'(w_push) - c_CNT_WIDTH'(w_pop);
        end
    end

    // Prefetch storage; cleared on reset so the presented head reads as zero
    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_pcMem[i]    <= '0;
                r_instrMem[i] <= '0;
            end
        end else if (w_push) begin
            r_pcMem[r_wrPtr]    <= r_inflightPc;
            r_instrMem[r_wrPtr] <= imemData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Directed timing scenarios
//                plus a randomized phase; a PC-sequence scoreboard checks
//                every accepted instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          XLEN       = 32;
    localparam int          IW         = 32;
    localparam int          DEPTH      = 256;
    localparam int          FDEPTH     = 4;
    localparam logic [31:0] RESET_PC   = 32'h0;

    logic        clk = 1'b0;
    logic        rstN;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [7:0]  imemAddr;
    logic [31:0] imemData;
    logic        idValid;
    logic        idReady;
    logic [31:0] idPc;
    logic [31:0] idInstr;
    logic [2:0]  fifoCount;

    logic [31:0] imem [DEPTH];
    logic [31:0] sbNext;
    int          checks = 0;
    int          errors = 0;

    fetch_unit #(
        .XLEN(XLEN), .INSTRUCTION_WIDTH(IW), .IM_MEM_DEPTH(DEPTH),
        .FIFO_DEPTH(FDEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rstN(rstN), .redirectValid(redirectValid),
        .redirectPc(redirectPc), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemData(imemData), .idValid(idValid), .idReady(idReady),
        .idPc(idPc), .idInstr(idInstr), .fifoCount(fifoCount)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory, one cycle read latency
    always @(posedge clk) begin
        if (imemReq) imemData <= imem[imemAddr];
    end

    function automatic logic [31:0] expInstr(input logic [31:0] pc);
        return imem[pc[9:2]];
    endfunction

    // Scoreboard: accepted instructions must be consecutive words starting
    // from the reset PC or the last (aligned) redirect target
    always @(negedge clk) begin
        if (!rstN) begin
            sbNext = RESET_PC;
        end else if (redirectValid) begin
            sbNext = redirectPc & 32'hFFFF_FFFC;
        end else if (idValid === 1'b1 && idReady) begin
            checks++;
            if (idPc !== sbNext || idInstr !== expInstr(sbNext)) begin
                errors++;
                $display("FAIL scoreboard_pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                         idPc, idInstr, sbNext, expInstr(sbNext));
            end
            sbNext = sbNext + 32'd4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        rstN = 1'b0; redirectValid = 1'b0; redirectPc = '0; idReady = 1'b1;
        repeat (n) tick();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; redirectValid = 1'b0; redirectPc = '0; idReady = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (idValid !== 1'b0) begin errors++; $display("FAIL reset_idValid: got %b expected 0", idValid); end
        checks++;
        if (fifoCount !== 3'd0) begin errors++; $display("FAIL reset_fifoCount: got %0d expected 0", fifoCount); end
        checks++;
        if (imemReq !== 1'b0) begin errors++; $display("FAIL reset_imemReq: got %b expected 0", imemReq); end
        checks++;
        if (idPc !== 32'h0 || idInstr !== 32'h0) begin
            errors++; $display("FAIL reset_idOut: got pc=%h instr=%h expected 0/0", idPc, idInstr);
        end
        tick();
    endtask

    task automatic test_free_run();
        doReset(2);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== RESET_PC[9:2]) begin
                    errors++; $display("FAIL free_first_req: got req=%b addr=%h expected 1/%h", imemReq, imemAddr, RESET_PC[9:2]);
                end
            end
            checks++;
            if (c < 2) begin
                if (idValid !== 1'b0) begin errors++; $display("FAIL free_latency c%0d: got idValid=%b expected 0", c, idValid); end
            end else if (idValid !== 1'b1 || idPc !== RESET_PC + 32'(4*(c-2))
                         || idInstr !== expInstr(RESET_PC + 32'(4*(c-2)))) begin
                errors++; $display("FAIL free_stream c%0d: got v=%b pc=%h expected v=1 pc=%h", c, idValid, idPc, RESET_PC + 32'(4*(c-2)));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] expPc;
        doReset(2);
        for (int c = 0; c < 25; c++) begin
            idReady = !(c >= 3 && c <= 12);
            @(negedge clk);
            if (c >= 3 && c <= 12) expPc = RESET_PC + 32'd4;
            else if (c >= 13)      expPc = RESET_PC + 32'd4 + 32'(4*(c-13));
            else                   expPc = RESET_PC + 32'(4*(c-2));
            if (c >= 2) begin
                checks++;
                if (idValid !== 1'b1 || idPc !== expPc) begin
                    errors++; $display("FAIL stall_stream c%0d: got v=%b pc=%h expected v=1 pc=%h", c, idValid, idPc, expPc);
                end
            end
            if (c == 8 || c == 12) begin
                checks++;
                if (fifoCount !== 3'd4 || imemReq !== 1'b0) begin
                    errors++; $display("FAIL stall_full c%0d: got count=%0d req=%b expected 4/0", c, fifoCount, imemReq);
                end
            end
            if (c == 13) begin
                checks++;
                if (imemReq !== 1'b1) begin errors++; $display("FAIL stall_release_req: got %b expected 1", imemReq); end
            end
            tick();
        end
        idReady = 1'b1;
    endtask

    task automatic test_redirect();
        doReset(2);
        for (int c = 0; c < 12; c++) begin
            redirectValid = (c == 6);
            redirectPc    = (c == 6) ? 32'h40 : 32'h1234_5678;
            @(negedge clk);
            checks++;
            if (c >= 2 && c <= 5) begin
                if (idValid !== 1'b1 || idPc !== 32'(4*(c-2))) begin
                    errors++; $display("FAIL redir_pre c%0d: got v=%b pc=%h expected v=1 pc=%h", c, idValid, idPc, 32'(4*(c-2)));
                end
            end else if (c >= 6 && c <= 8) begin
                if (idValid !== 1'b0) begin errors++; $display("FAIL redir_gap c%0d: got idValid=%b expected 0", c, idValid); end
            end else if (c >= 9) begin
                if (idValid !== 1'b1 || idPc !== 32'h40 + 32'(4*(c-9)) || idInstr !== expInstr(32'h40 + 32'(4*(c-9)))) begin
                    errors++; $display("FAIL redir_target c%0d: got v=%b pc=%h expected v=1 pc=%h", c, idValid, idPc, 32'h40 + 32'(4*(c-9)));
                end
            end
            if (c == 6) begin
                checks++;
                if (imemReq !== 1'b0) begin errors++; $display("FAIL redir_noreq: got %b expected 0", imemReq); end
            end
            if (c == 7) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 8'h10) begin
                    errors++; $display("FAIL redir_req: got req=%b addr=%h expected 1/10", imemReq, imemAddr);
                end
            end
            tick();
        end
        redirectValid = 1'b0;
    endtask

    task automatic test_redirect_align_b2b();
        logic        expValid;
        logic [31:0] expPc;
        doReset(2);
        for (int c = 0; c < 15; c++) begin
            redirectValid = (c == 5 || c == 9 || c == 10);
            redirectPc    = (c == 5) ? 32'h43 : (c == 9) ? 32'h80 : (c == 10) ? 32'hC0 : 32'hDEAD_BEEF;
            @(negedge clk);
            expValid = 1'b0; expPc = '0;
            if (c >= 2 && c <= 4)        begin expValid = 1'b1; expPc = 32'(4*(c-2)); end
            else if (c == 8)             begin expValid = 1'b1; expPc = 32'h40; end
            else if (c >= 13)            begin expValid = 1'b1; expPc = 32'hC0 + 32'(4*(c-13)); end
            checks++;
            if (idValid !== expValid || (expValid && idPc !== expPc)) begin
                errors++; $display("FAIL align_b2b c%0d: got v=%b pc=%h expected v=%b pc=%h", c, idValid, idPc, expValid, expPc);
            end
            if (c == 11) begin
                checks++;
                if (imemReq !== 1'b1 || imemAddr !== 8'h30) begin
                    errors++; $display("FAIL b2b_req: got req=%b addr=%h expected 1/30", imemReq, imemAddr);
                end
            end
            tick();
        end
        redirectValid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        doReset(2);
        idReady = 1'b0;
        for (int c = 0; c < 13; c++) begin
            rstN    = (c != 8);
            idReady = (c >= 9);
            @(negedge clk);
            if (c == 7) begin
                checks++;
                if (fifoCount !== 3'd4) begin errors++; $display("FAIL mid_full: got %0d expected 4", fifoCount); end
            end
            if (c == 8) begin
                checks++;
                if (imemReq !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b expected 0", imemReq); end
            end
            if (c == 9) begin
                checks++;
                if (fifoCount !== 3'd0 || idValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== RESET_PC[9:2]) begin
                    errors++; $display("FAIL mid_after_rst: got count=%0d v=%b req=%b addr=%h expected 0/0/1/%h",
                                       fifoCount, idValid, imemReq, imemAddr, RESET_PC[9:2]);
                end
            end
            if (c == 11) begin
                checks++;
                if (idValid !== 1'b1 || idPc !== RESET_PC) begin
                    errors++; $display("FAIL mid_restart: got v=%b pc=%h expected 1/%h", idValid, idPc, RESET_PC);
                end
            end
            tick();
        end
        rstN = 1'b1; idReady = 1'b1;
    endtask

    task automatic test_wrap();
        doReset(2);
        for (int c = 0; c < 8; c++) begin
            redirectValid = (c == 2);
            redirectPc    = 32'hFFFF_FFFC;
            @(negedge clk);
            if (c == 5 || c == 6) begin
                checks++;
                if (idValid !== 1'b1 || idPc !== ((c == 5) ? 32'hFFFF_FFFC : 32'h0)) begin
                    errors++; $display("FAIL wrap c%0d: got v=%b pc=%h expected v=1 pc=%h", c, idValid, idPc, (c == 5) ? 32'hFFFF_FFFC : 32'h0);
                end
            end
            tick();
        end
        redirectValid = 1'b0;
    endtask

    task automatic test_random();
        logic        prevHold;
        logic [31:0] prevPc;
        logic [31:0] prevInstr;
        logic        slowMode;
        prevHold = 1'b0; prevPc = '0; prevInstr = '0; slowMode = 1'b0;
        doReset(2);
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) slowMode = ($urandom_range(1) == 1);
            rstN          = ($urandom_range(199) != 0);
            redirectValid = ($urandom_range(19) == 0);
            redirectPc    = $urandom;
            idReady       = slowMode ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            @(negedge clk);
            checks++;
            if (fifoCount > 3'd4 || (redirectValid && idValid !== 1'b0) || (!rstN && imemReq !== 1'b0)) begin
                errors++; $display("FAIL rand_invariant c%0d: got count=%0d v=%b req=%b redir=%b rstN=%b",
                                   c, fifoCount, idValid, imemReq, redirectValid, rstN);
            end
            if (prevHold && rstN && !redirectValid) begin
                checks++;
                if (idValid !== 1'b1 || idPc !== prevPc || idInstr !== prevInstr) begin
                    errors++; $display("FAIL rand_hold c%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                                       c, idValid, idPc, idInstr, prevPc, prevInstr);
                end
            end
            prevHold  = (idValid === 1'b1) && !idReady && rstN;
            prevPc    = idPc;
            prevInstr = idInstr;
            tick();
        end
        rstN = 1'b1; redirectValid = 1'b0; idReady = 1'b1;
    endtask

    initial begin
        rstN = 1'b0; redirectValid = 1'b0; redirectPc = '0; idReady = 1'b1;
        for (int k = 0; k < DEPTH; k++) imem[k] = $urandom;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_align_b2b();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
